// File: rtl/src_pkg.sv
// src_pkg: shared types and constants for the control unit.
package src_pkg;
  localparam int STEP_W = 3;
  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_LD   = 5'd1,
    OP_ST   = 5'd3,
    OP_LA   = 5'd5,
    OP_BR   = 5'd8,
    OP_ADD  = 5'd12,
    OP_ADDI = 5'd13,
    OP_SUB  = 5'd14,
    OP_STOP = 5'd31
  } opcode_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic ma_in;
    logic inc4;
    logic c_in;
    logic c_out;
    logic a_in;
    logic add;
    logic sub;
    logic read;
    logic write;
    logic md_out;
    logic md_in;
    logic ir_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_out;
    logic ba_out;
    logic r_in;
    logic c2_out;
    logic con_in;
  } ctrl_t;
  function automatic logic is_legal(logic [4:0] op);
    return op inside {OP_NOP, OP_LD, OP_ST, OP_LA, OP_BR, OP_ADD, OP_ADDI, OP_SUB, OP_STOP};
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: start/opcode/handshake inputs and strobe/status outputs of the control unit.
interface control_unit_if;
  import src_pkg::*;
  logic start_i;
  logic [4:0] opcode_i;
  logic con_i;
  logic mem_done_i;
  ctrl_t ctrl_o;
  logic run_o;
  logic illegal_o;
  logic [STEP_W-1:0] step_o;
  modport master (output start_i, opcode_i, con_i, mem_done_i, input ctrl_o, run_o, illegal_o, step_o);
  modport slave (input start_i, opcode_i, con_i, mem_done_i, output ctrl_o, run_o, illegal_o, step_o);
endinterface

// File: rtl/src_step_cnt.sv
// src_step_cnt: T-step counter with clear, hold and saturating advance.
module src_step_cnt
  import src_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              hold_i,
  output logic [STEP_W-1:0] step_o
);
  logic [STEP_W-1:0] step_q, step_d;
  always_comb step_d = clr_i ? '0 : (hold_i || &step_q) ? step_q : step_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) step_q <= '0;
    else step_q <= step_d;
  end
  assign step_o = step_q;
endmodule

// File: rtl/control_unit.sv
// control_unit: IDLE/RUN/HALT sequencer decoding state, step and opcode into datapath strobes.
module control_unit
  import src_pkg::*;
(
  input logic           clk,
  input logic           rst,
  control_unit_if.slave bus_io
);
  state_e state_q, state_d;
  logic illegal_q, illegal_d;
  logic [STEP_W-1:0] step_q;
  opcode_e op;
  logic in_run, at_t3, legal, wait_w, end_w, clr_w;
  ctrl_t ctrl;
  assign op = opcode_e'(bus_io.opcode_i);
  assign legal = is_legal(bus_io.opcode_i);
  assign in_run = state_q == S_RUN;
  assign at_t3 = in_run && step_q == 3'd3;
  always_comb begin
    state_d = state_q == S_IDLE ? (bus_io.start_i ? S_RUN : S_IDLE) :
              state_q == S_RUN ? ((at_t3 && (op == OP_STOP || !legal)) ? S_HALT : S_RUN) : S_HALT;
    illegal_d = illegal_q | (at_t3 & ~legal);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
    end
  end
  // st finishes only once its write handshake arrives in T7
  assign wait_w = step_q == 3'd1 || (op == OP_LD && step_q == 3'd6) || (op == OP_ST && step_q == 3'd7);
  assign end_w = (step_q == 3'd3 && op == OP_NOP) || (step_q == 3'd4 && op == OP_BR) ||
                 (step_q == 3'd5 && op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LA}) ||
                 (step_q == 3'd7 && (op == OP_LD || (op == OP_ST && bus_io.mem_done_i)));
  assign clr_w = !in_run || state_d != S_RUN || end_w;
  src_step_cnt u_step (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_w),
    .hold_i (wait_w && !bus_io.mem_done_i),
    .step_o (step_q)
  );
  always_comb begin
    ctrl = '0;
    if (in_run) begin
      case (step_q)
        3'd0: begin
          ctrl.pc_out = 1'b1;
          ctrl.ma_in = 1'b1;
          ctrl.inc4 = 1'b1;
          ctrl.c_in = 1'b1;
          ctrl.read = 1'b1;
        end
        3'd1: begin
          ctrl.c_out = 1'b1;
          ctrl.pc_in = 1'b1;
        end
        3'd2: begin
          ctrl.md_out = 1'b1;
          ctrl.ir_in = 1'b1;
        end
        3'd3: begin
          ctrl.grb = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LA, OP_LD, OP_ST};
          ctrl.ba_out = op inside {OP_LA, OP_LD, OP_ST};
          ctrl.a_in = ctrl.grb;
          ctrl.grc = op == OP_BR;
          ctrl.con_in = op == OP_BR;
          ctrl.r_out = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_BR};
        end
        3'd4: begin
          ctrl.grc = op inside {OP_ADD, OP_SUB};
          ctrl.c2_out = op inside {OP_ADDI, OP_LA, OP_LD, OP_ST};
          ctrl.add = op == OP_ADD || ctrl.c2_out;
          ctrl.sub = op == OP_SUB;
          ctrl.c_in = ctrl.grc || ctrl.c2_out;
          ctrl.grb = op == OP_BR;
          ctrl.r_out = ctrl.grc || ctrl.grb;
          ctrl.pc_in = op == OP_BR && bus_io.con_i;
        end
        3'd5: begin
          ctrl.c_out = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LA, OP_LD, OP_ST};
          ctrl.gra = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LA};
          ctrl.r_in = ctrl.gra;
          ctrl.ma_in = op inside {OP_LD, OP_ST};
          ctrl.read = op == OP_LD;
        end
        3'd6: begin
          ctrl.gra = op == OP_ST;
          ctrl.r_out = ctrl.gra;
          ctrl.md_in = ctrl.gra;
          ctrl.write = ctrl.gra;
        end
        default: begin
          ctrl.md_out = op == OP_LD;
          ctrl.gra = ctrl.md_out;
          ctrl.r_in = ctrl.md_out;
        end
      endcase
    end
  end
  assign bus_io.ctrl_o = ctrl;
  assign bus_io.run_o = in_run;
  assign bus_io.illegal_o = illegal_q;
  assign bus_io.step_o = step_q;
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset, synchronous and active-low; sampled on rising clk.
REQ-003 start  in  1  one-cycle pulse that begins instruction execution from IDLE.
REQ-004 opcode  in  5  instruction opcode from IR[31:27]; valid from step T3 onward.
REQ-005 con  in  1  branch condition from the CON flip-flop; sampled in br T4.
REQ-006 mem_done  in  1  memory handshake; high for one cycle when a Read or Write completes.
REQ-007 ctrl  out  ctrl_t  packed one-hot-per-signal strobes: PCout, PCin, MAin, INC4, Cin, Cout, Ain, ADD, SUB, Read, Write, MDout, MDin, IRin, Gra, Grb, Grc, Rout, BAout, Rin, c2out, CONin.
REQ-008 run  out  1  high while executing, i.e. while state is not IDLE or HALT.
REQ-009 illegal  out  1  sticky flag, set when an undefined opcode is decoded.
REQ-010 step  out  3  current step number T0..T7, exposed for debug.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and HALT. IDLE->RUN on start. RUN->HALT on stop or on an illegal opcode. HALT is left only by reset.
REQ-012 ctrl SHALL be a Moore decode of the registered state, step and opcode, and SHALL be all-zero outside RUN.
REQ-013 Fetch SHALL run in every instruction: T0 asserts PCout, MAin, INC4, Cin, Read. T1 asserts Cout, PCin and waits. T2 asserts MDout, IRin.
REQ-014 A wait step SHALL hold its strobes and step value until mem_done=1, then advance on the next edge. mem_done SHALL be ignored in all other steps.
REQ-015 add (12) and sub (14) SHALL execute as: T3 Grb, Rout, Ain. T4 Grc, Rout, ADD or SUB, Cin. T5 Cout, Gra, Rin, end.
REQ-016 addi (13) SHALL execute as: T3 Grb, Rout, Ain. T4 c2out, ADD, Cin. T5 Cout, Gra, Rin, end.
REQ-017 la (5) SHALL execute as: T3 Grb, BAout, Ain. T4 c2out, ADD, Cin. T5 Cout, Gra, Rin, end.
REQ-018 ld (1) SHALL execute as: T3 to T4 as la. T5 Cout, MAin, Read. T6 wait. T7 MDout, Gra, Rin, end.
REQ-019 st (3) SHALL execute as: T3 to T4 as la. T5 Cout, MAin. T6 Gra, Rout, MDin, Write. T7 wait, end.
REQ-020 br (8) SHALL execute as: T3 Grc, Rout, CONin. T4 Grb, Rout, with PCin only if con=1, end.
REQ-021 nop (0) SHALL end at T3. stop (31) SHALL enter HALT at T3 with no strobes asserted.
REQ-022 Any other opcode at T3 SHALL enter HALT, set illegal and assert no strobes.
REQ-023 The end condition SHALL reset step to T0 on the next edge while remaining in RUN. The step counter SHALL never wrap past T7.
REQ-024 start SHALL be ignored in RUN and in HALT.
REQ-025 With no wait stall, latency from T0 to end SHALL be: add/sub/addi/la 6 cycles, br 5, nop 4.

Reset
REQ-026 When rst=0 at a rising edge: state=IDLE, step=T0, ctrl=0, run=0, illegal=0. This SHALL hold even mid-instruction or mid-wait.
REQ-027 The first edge with rst=1 SHALL leave the block in IDLE; execution SHALL require a fresh start pulse.

Structure
REQ-028 Package src_pkg SHALL hold the opcode_e enum (5-bit values above), the state_e enum, the ctrl_t packed struct and the constant STEP_W=3.
REQ-029 The step counter, with its clear, hold-on-wait and advance logic, SHALL be the sub-module src_step_cnt. The decode SHALL stay in control_unit.

Verification
REQ-030 Reset then start, opcode=12, mem_done pulsed in T1 -> ctrl matches REQ-013 and REQ-015 step by step; Rin in T5; back to T0 with run=1.
REQ-031 ld with mem_done held low for 3 cycles in T6 -> step stays 6 and Read is not reasserted; T7 asserts MDout, Gra, Rin.
REQ-032 br with con=0, then br with con=1 -> PCin absent in T4 for the first, present in T4 for the second.
REQ-033 opcode=31 -> HALT and run=0; opcode=2 -> HALT and illegal=1; start in HALT -> no change.
REQ-034 rst=0 asserted during st T6 -> next cycle ctrl=0, step=0, state IDLE; Write is never asserted again without a new start.
REQ-035 start pulsed during RUN at T4 of addi -> sequence unaffected; end at T5.
